// File: rtl/fifo_depth_n.sv
// Synchronous single-clock FIFO with first-word fall-through output.
// Occupancy, full/empty and almost thresholds are derived from wrap-bit pointers.
// Rejected writes (full) and reads (empty) latch sticky error flags until reset.
module fifo_depth_n #(
  parameter int unsigned bw     = 4,
  parameter int unsigned depth  = 8,
  parameter int unsigned ptr_bw = 3,
  parameter int unsigned af_th  = 6,
  parameter int unsigned ae_th  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [bw-1:0]     in,
  input  logic              wr,
  input  logic              rd,
  output logic [bw-1:0]     out,
  output logic              o_full,
  output logic              o_empty,
  output logic [ptr_bw:0]   o_count,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_ovf,
  output logic              o_udf
);

  localparam logic [ptr_bw:0] AfTh = (ptr_bw + 1)'(af_th);
  localparam logic [ptr_bw:0] AeTh = (ptr_bw + 1)'(ae_th);

  logic [bw-1:0]     mem_q [depth];
  logic [ptr_bw:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_bw:0]   rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // Status flags come straight from the pre-edge pointers.
  always_comb begin
    o_empty        = (wr_ptr_q == rd_ptr_q);
    o_full         = (wr_ptr_q[ptr_bw-1:0] == rd_ptr_q[ptr_bw-1:0]) &&
                     (wr_ptr_q[ptr_bw] != rd_ptr_q[ptr_bw]);
    o_count        = wr_ptr_q - rd_ptr_q;
    o_almost_full  = (o_count >= AfTh);
    o_almost_empty = (o_count <= AeTh);
    o_ovf          = ovf_q;
    o_udf          = udf_q;
    out            = mem_q[rd_ptr_q[ptr_bw-1:0]];
  end

  // Accept/reject decisions and next pointer/sticky-flag state.
  always_comb begin
    wr_acc   = wr && !o_full;
    rd_acc   = rd && !o_empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr && o_full) ovf_d = 1'b1;
    if (rd && o_empty) udf_d = 1'b1;
  end

  // Pointer and sticky-flag registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is intentionally not reset; a stray write while in reset
  // lands in a slot the reset pointers already treat as free.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ptr_bw-1:0]] <= in;
  end

endmodule

// File: tb/tb_fifo_depth_n.sv
// Self-checking bench for fifo_depth_n: status table plus data scoreboard.
module tb_fifo_depth_n;

  localparam int BW     = 4;
  localparam int DEPTH  = 8;
  localparam int AF_TH  = 6;
  localparam int AE_TH  = 2;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [BW-1:0] din;
    logic [3:0]    cnt;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] din = '0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [BW-1:0] out;
  logic          o_full, o_empty, o_almost_full, o_almost_empty, o_ovf, o_udf;
  logic [3:0]    o_count;

  int            checks = 0;
  int            failures = 0;
  logic [BW-1:0] sb_q[$];
  vec_t          vecs[$];

  fifo_depth_n #(
    .bw(4), .depth(8), .ptr_bw(3), .af_th(6), .ae_th(2)
  ) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd), .out(out),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .o_ovf(o_ovf), .o_udf(o_udf)
  );

  always #5 clk = ~clk;

  task automatic add(input logic w, input logic r, input logic [BW-1:0] d,
                     input logic [3:0] c, input logic f, input logic e,
                     input logic ov, input logic ud);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d; v.cnt = c;
    v.full = f; v.empty = e; v.ovf = ov; v.udf = ud;
    vecs.push_back(v);
  endtask

  task automatic check_status(input string name, input logic [3:0] c, input logic f,
                              input logic e, input logic ov, input logic ud);
    logic [9:0] act, exp;
    act = {o_count, o_full, o_empty, o_almost_full, o_almost_empty, o_ovf, o_udf};
    exp = {c, f, e, (c >= 4'(AF_TH)), (c <= 4'(AE_TH)), ov, ud};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {count,full,empty,af,ae,ovf,udf} got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [BW-1:0] exp);
    checks++;
    if (out !== exp) begin
      failures++;
      $display("FAIL %s: out got %h want %h", name, out, exp);
    end
  endtask

  // One clock: model acceptance on pre-edge occupancy, compare popped data, step.
  task automatic drive(input logic w, input logic r, input logic [BW-1:0] d);
    bit was_full;
    wr = w; rd = r; din = d;
    was_full = (sb_q.size() == DEPTH);
    if (r && sb_q.size() > 0) check_data("read_data", sb_q.pop_front());
    if (w && !was_full) sb_q.push_back(d);
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    if (sb_q.size() > 0) check_data("head", sb_q[0]);
  endtask

  initial begin
    // Fill 1..8, drain, refill, full rd&wr, drain, empty rd&wr.
    for (int i = 0; i < 8; i++) add(1, 0, 4'(i + 1), 4'(i + 1), i == 7, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 4'h0, 4'(7 - i), 0, i == 7, 0, 0);
    for (int i = 0; i < 8; i++) add(1, 0, 4'(i + 9), 4'(i + 1), i == 7, 0, 0, 0);
    add(1, 1, 4'h5, 4'd7, 0, 0, 1, 0);
    for (int i = 0; i < 7; i++) add(0, 1, 4'h0, 4'(6 - i), 0, i == 6, 1, 0);
    add(1, 1, 4'hA, 4'd1, 0, 0, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    check_status("in_reset", 4'd0, 0, 1, 0, 0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    check_status("after_release", 4'd0, 0, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].full, vecs[i].empty,
                   vecs[i].ovf, vecs[i].udf);
    end
    check_data("empty_rdwr_out", 4'hA);

    // Bring occupancy to 3, then stream through enough words to wrap twice.
    drive(1, 0, 4'h3);
    drive(1, 0, 4'h7);
    check_status("stream_pre", 4'd3, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 4'($urandom_range(0, 15)));
      check_status($sformatf("stream%0d", i), 4'd3, 0, 0, 1, 1);
    end

    // Count 5, then asynchronous reset in the middle of the cycle.
    drive(1, 0, 4'h1);
    drive(1, 0, 4'h2);
    check_status("pre_async", 4'd5, 0, 0, 1, 1);
    #2 reset = 1'b0;
    #1;
    check_status("async_reset", 4'd0, 0, 1, 0, 0);
    sb_q.delete();
    wr = 1'b1; rd = 1'b1; din = 4'hF;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    check_status("ignored_in_reset", 4'd0, 0, 1, 0, 0);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    drive(1, 0, 4'h3);
    drive(1, 0, 4'h4);
    check_status("post_reset_fill", 4'd2, 0, 0, 0, 0);
    drive(0, 1, 4'h0);
    drive(0, 1, 4'h0);
    check_status("post_reset_drain", 4'd0, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_depth_n.md
FIFO_DEPTH_N -- requirements
Module: fifo_depth_n

Interface
REQ-001 The block SHALL have parameter bw, default 4, meaning the data word width in bits.
REQ-002 The block SHALL have parameter depth, default 8, meaning the number of entries; legal values are powers of two from 2 to 64.
REQ-003 The block SHALL have parameter ptr_bw, default 3, meaning log2(depth); any other value is illegal.
REQ-004 The block SHALL have parameter af_th, default 6, meaning the almost-full threshold in entries, legal range 1..depth-1.
REQ-005 The block SHALL have parameter ae_th, default 2, meaning the almost-empty threshold in entries, legal range 1..depth-1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port in, input, bw bits: write data.
REQ-009 The block SHALL have port wr, input, 1 bit: write request.
REQ-010 The block SHALL have port rd, input, 1 bit: read request.
REQ-011 The block SHALL have port out, output, bw bits: head-of-queue data (first-word fall-through).
REQ-012 The block SHALL have port o_full, output, 1 bit: queue holds depth entries.
REQ-013 The block SHALL have port o_empty, output, 1 bit: queue holds 0 entries.
REQ-014 The block SHALL have port o_count, output, ptr_bw+1 bits: current occupancy, 0..depth.
REQ-015 The block SHALL have port o_almost_full, output, 1 bit: o_count >= af_th.
REQ-016 The block SHALL have port o_almost_empty, output, 1 bit: o_count <= ae_th.
REQ-017 The block SHALL have port o_ovf, output, 1 bit: sticky overflow error.
REQ-018 The block SHALL have port o_udf, output, 1 bit: sticky underflow error.

Function
REQ-019 Storage SHALL be depth x bw registers; write and read pointers SHALL be ptr_bw+1 bits, low ptr_bw bits index the array, MSB is the wrap bit.
REQ-020 A write SHALL be accepted iff wr=1 and o_full=0 at the clock edge: mem[wr_ptr] <= in, wr_ptr increments by 1 modulo 2^(ptr_bw+1).
REQ-021 A read SHALL be accepted iff rd=1 and o_empty=0 at the clock edge: rd_ptr increments by 1 modulo 2^(ptr_bw+1).
REQ-022 out SHALL be combinationally mem[rd_ptr low bits] (depth:1 mux tree, zero-cycle read latency); value is don't-care while o_empty=1.
REQ-023 o_empty SHALL be 1 iff wr_ptr == rd_ptr; o_full SHALL be 1 iff low bits equal and wrap bits differ.
REQ-024 o_count SHALL equal wr_ptr - rd_ptr modulo 2^(ptr_bw+1), combinational from pointers.
REQ-025 Flags SHALL be evaluated on the pre-edge state: wr while full is rejected even if rd is accepted the same cycle; rd while empty is rejected even if wr is accepted the same cycle.
REQ-026 Simultaneous accepted rd and wr SHALL leave o_count unchanged and both pointers advance.
REQ-027 A rejected wr (wr=1, o_full=1) SHALL set o_ovf to 1 on that edge; data and pointers unchanged.
REQ-028 A rejected rd (rd=1, o_empty=1) SHALL set o_udf to 1 on that edge; pointers unchanged.
REQ-029 o_ovf and o_udf SHALL stay 1 until reset.
REQ-030 Pointer wrap past depth-1 SHALL be seamless; no entry lost or duplicated.
REQ-031 Write-to-out latency SHALL be one edge: a word written into an empty queue appears on out and o_empty falls after that edge.

Reset
REQ-032 reset=0 SHALL immediately, without clk, clear wr_ptr, rd_ptr, o_ovf, o_udf to 0.
REQ-033 During/after reset SHALL hold o_empty=1, o_full=0, o_count=0, o_almost_empty=1, o_almost_full=0.
REQ-034 Storage array SHALL NOT be reset; contents are don't-care.
REQ-035 Reset asserted mid-operation SHALL discard all queued data; first read after release returns first word written after release.
REQ-036 wr/rd SHALL be ignored on any edge while reset=0.

Verification
REQ-037 Reset, then write 8 words 0x1..0x8 (depth=8) -> o_full=1 after 8th edge, o_count=8, o_almost_full=1 from count 6.
REQ-038 From full, read 8 times -> out sequence 0x1..0x8 in order, o_empty=1 after 8th edge, o_udf=0, o_ovf=0.
REQ-039 Full queue, wr=1 and rd=1 same cycle -> read accepted, write rejected, o_count=7, o_ovf=1.
REQ-040 Empty queue, wr=1 in=0xA and rd=1 same cycle -> o_count=1, out=0xA, o_udf=1.
REQ-041 20 cycles of continuous rd&wr with count held at 3 (pointer wrap twice) -> out equals input delayed by 3 accepted words, o_count=3 throughout.
REQ-042 Assert reset asynchronously mid-cycle with o_count=5 -> o_count=0, o_empty=1 before next clk edge; sticky flags cleared.
